// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_arbiter
//  Purpose  : Shares the single instruction-memory port between two
//             requesters (port 0 = fetch FSM, port 1 = loader/debug reader).
//             Round-robin arbitration, one outstanding memory transaction at
//             a time, and a per-transaction response timeout. Every output
//             is driven straight from a flop.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    m0_req / m0_addr    port 0 request, held with address until m0_gnt
//    m0_gnt              1-cycle pulse, port 0 request accepted
//    m0_valid / m0_data  1-cycle pulse with returned instruction
//    m0_err              1-cycle pulse, port 0 transaction timed out
//    m1_*                identical set for port 1
//    mem_request         1-cycle request strobe to inst_mem
//    mem_addr            address to inst_mem, held for the whole transaction
//    mem_valid/mem_inst  inst_mem response strobe and data
//    busy                high while a transaction is in ISSUE or WAIT
// ============================================================================
module imem_arbiter #(
    parameter int unsigned INST_WIDTH      = 32,
    parameter int unsigned INST_ADDR_WIDTH = 7,
    parameter int unsigned TIMEOUT         = 15,
    parameter int unsigned TMR_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // port 0
    input  logic                       m0_req,
    input  logic [INST_ADDR_WIDTH-1:0] m0_addr,
    output logic                       m0_gnt,
    output logic                       m0_valid,
    output logic                       m0_err,
    output logic [INST_WIDTH-1:0]      m0_data,
    // port 1
    input  logic                       m1_req,
    input  logic [INST_ADDR_WIDTH-1:0] m1_addr,
    output logic                       m1_gnt,
    output logic                       m1_valid,
    output logic                       m1_err,
    output logic [INST_WIDTH-1:0]      m1_data,
    // instruction memory side
    output logic                       mem_request,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    input  logic                       mem_valid,
    input  logic [INST_WIDTH-1:0]      mem_inst,
    // status
    output logic                       busy
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Last WAIT cycle before the transaction is abandoned.
    localparam logic [TMR_WIDTH-1:0] c_TMR_LAST = TMR_WIDTH'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                     r_state;
    logic                       r_owner;        // port being served
    logic                       r_last_owner;   // port served most recently
    logic [TMR_WIDTH-1:0]       r_timer;
    logic [INST_ADDR_WIDTH-1:0] r_mem_addr;
    logic                       r_mem_request;
    logic                       r_busy;
    logic [1:0]                 r_gnt;          // index = port number
    logic [1:0]                 r_valid;
    logic [1:0]                 r_err;
    logic [INST_WIDTH-1:0]      r_m0_data;
    logic [INST_WIDTH-1:0]      r_m1_data;

    // ------------------------------------------------------------------------
    // Arbitration (only consulted in IDLE)
    // ------------------------------------------------------------------------
    logic                       w_any_req;
    logic                       w_pick;
    logic [INST_ADDR_WIDTH-1:0] w_pick_addr;

    always_comb begin
        w_any_req   = m0_req | m1_req;
        // On a tie the port that was not served last wins; otherwise the
        // lone requester wins. With no requester w_pick is a don't-care.
        if (m0_req && m1_req) begin
            w_pick = ~r_last_owner;
        end else begin
            w_pick = m1_req;
        end
        w_pick_addr = w_pick ? m1_addr : m0_addr;
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            // Pretend port 1 was served last so port 0 wins the first tie.
            r_last_owner  <= 1'b1;
            r_timer       <= '0;
            r_mem_addr    <= '0;
            r_mem_request <= 1'b0;
            r_busy        <= 1'b0;
            r_gnt         <= 2'b00;
            r_valid       <= 2'b00;
            r_err         <= 2'b00;
            r_m0_data     <= '0;
            r_m1_data     <= '0;
        end else begin
            // Pulse outputs default low and are raised for one cycle only.
            r_gnt         <= 2'b00;
            r_valid       <= 2'b00;
            r_err         <= 2'b00;
            r_mem_request <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // mem_valid seen here is a stray response and is dropped.
                    if (w_any_req) begin
                        r_owner       <= w_pick;
                        r_mem_addr    <= w_pick_addr;
                        r_gnt[w_pick] <= 1'b1;
                        r_mem_request <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // The request strobe was presented this cycle; any
                    // mem_valid here predates it and is ignored.
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // A response arriving on the final timeout cycle still
                    // counts, so mem_valid is tested first.
                    if (mem_valid) begin
                        r_valid[r_owner] <= 1'b1;
                        if (r_owner) begin
                            r_m1_data <= mem_inst;
                        end else begin
                            r_m0_data <= mem_inst;
                        end
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_err[r_owner] <= 1'b1;
                        if (r_owner) begin
                            r_m1_data <= '0;
                        end else begin
                            r_m0_data <= '0;
                        end
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign m0_gnt      = r_gnt[0];
    assign m0_valid    = r_valid[0];
    assign m0_err      = r_err[0];
    assign m0_data     = r_m0_data;
    assign m1_gnt      = r_gnt[1];
    assign m1_valid    = r_valid[1];
    assign m1_err      = r_err[1];
    assign m1_data     = r_m1_data;
    assign mem_request = r_mem_request;
    assign mem_addr    = r_mem_addr;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_arbiter
//  Purpose  : Directed self-checking bench for imem_arbiter. Inputs change
//             1 ns after the rising edge; outputs are checked at the same
//             point, so each check sees the flops updated by that edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req;
    logic [6:0]  m0_addr;
    logic        m0_gnt;
    logic        m0_valid;
    logic        m0_err;
    logic [31:0] m0_data;
    logic        m1_req;
    logic [6:0]  m1_addr;
    logic        m1_gnt;
    logic        m1_valid;
    logic        m1_err;
    logic [31:0] m1_data;
    logic        mem_request;
    logic [6:0]  mem_addr;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic        busy;

    int n_vec;
    int n_fail;

    imem_arbiter #(
        .INST_WIDTH      (32),
        .INST_ADDR_WIDTH (7),
        .TIMEOUT         (15),
        .TMR_WIDTH       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_gnt      (m0_gnt),
        .m0_valid    (m0_valid),
        .m0_err      (m0_err),
        .m0_data     (m0_data),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_gnt      (m1_gnt),
        .m1_valid    (m1_valid),
        .m1_err      (m1_err),
        .m1_data     (m1_data),
        .mem_request (mem_request),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_inst    (mem_inst),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int own;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;

        n_vec     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        m0_req    = 1'b0;
        m0_addr   = 7'h00;
        m1_req    = 1'b0;
        m1_addr   = 7'h00;
        mem_valid = 1'b0;
        mem_inst  = 32'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy",    32'(busy),        32'h0);
        chk("rst_memreq",  32'(mem_request), 32'h0);
        chk("rst_memaddr", 32'(mem_addr),    32'h0);
        chk("rst_m0_data", m0_data,          32'h0);
        chk("rst_m1_data", m1_data,          32'h0);
        chk("rst_gnts",    32'({m0_gnt, m1_gnt, m0_valid, m1_valid, m0_err, m1_err}), 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- single request, 2-cycle memory ----------------
        m0_req  = 1'b1;
        m0_addr = 7'h05;
        tick();                                     // t+1 : ISSUE
        chk("t1_m0_gnt",  32'(m0_gnt),      32'h1);
        chk("t1_memreq",  32'(mem_request), 32'h1);
        chk("t1_memaddr", 32'(mem_addr),    32'h05);
        chk("t1_busy",    32'(busy),        32'h1);
        chk("t1_m1_gnt",  32'(m1_gnt),      32'h0);
        m0_req = 1'b0;
        tick();                                     // t+2 : WAIT
        chk("t1_memreq_drop", 32'(mem_request), 32'h0);
        chk("t1_gnt_drop",    32'(m0_gnt),      32'h0);
        tick();                                     // t+3 : response
        mem_valid = 1'b1;
        mem_inst  = 32'hDEADBEEF;
        tick();                                     // t+4 : valid pulse
        mem_valid = 1'b0;
        chk("t1_m0_valid", 32'(m0_valid), 32'h1);
        chk("t1_m0_data",  m0_data,       32'hDEADBEEF);
        chk("t1_busy_end", 32'(busy),     32'h0);
        chk("t1_m1_quiet", 32'({m1_gnt, m1_valid, m1_err}), 32'h0);
        chk("t1_m1_data",  m1_data,       32'h0);
        tick();
        chk("t1_valid_pulse", 32'(m0_valid), 32'h0);
        chk("t1_data_hold",   m0_data,       32'hDEADBEEF);

        // ---------------- round robin after reset ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_d0  = 32'h0;
        exp_d1  = 32'h0;
        m0_addr = 7'h10;
        m1_addr = 7'h20;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            own = i % 2;
            tick();                                 // ISSUE
            chk("rr_m0_gnt",  32'(m0_gnt),   (own == 0) ? 32'h1 : 32'h0);
            chk("rr_m1_gnt",  32'(m1_gnt),   (own == 1) ? 32'h1 : 32'h0);
            chk("rr_memaddr", 32'(mem_addr), (own == 0) ? 32'h10 : 32'h20);
            tick();                                 // WAIT
            mem_valid = 1'b1;
            mem_inst  = 32'hA0000000 | 32'(i);
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();                                 // IDLE, valid pulse
            mem_valid = 1'b0;
            if (own == 0) exp_d0 = 32'hA0000000 | 32'(i);
            else          exp_d1 = 32'hA0000000 | 32'(i);
            chk("rr_m0_valid", 32'(m0_valid), (own == 0) ? 32'h1 : 32'h0);
            chk("rr_m1_valid", 32'(m1_valid), (own == 1) ? 32'h1 : 32'h0);
            chk("rr_m0_data",  m0_data, exp_d0);
            chk("rr_m1_data",  m1_data, exp_d1);
        end

        // ---------------- timeout on port 1 ----------------
        m1_req = 1'b1;
        tick();                                     // ISSUE
        chk("to_m1_gnt", 32'(m1_gnt), 32'h1);
        m1_req = 1'b0;
        for (int j = 0; j < 15; j++) tick();        // 15 WAIT cycles
        chk("to_busy_pre", 32'(busy),   32'h1);
        chk("to_err_pre",  32'(m1_err), 32'h0);
        tick();                                     // gnt + 16
        chk("to_m1_err",   32'(m1_err),   32'h1);
        chk("to_m1_valid", 32'(m1_valid), 32'h0);
        chk("to_m1_data",  m1_data,       32'h0);
        chk("to_busy",     32'(busy),     32'h0);
        chk("to_m0_data",  m0_data,       32'hA0000002);
        m0_req  = 1'b1;
        m0_addr = 7'h33;
        tick();
        chk("to_next_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("to_next_addr",   32'(mem_addr), 32'h33);
        m0_req = 1'b0;

        // ---------------- mem_valid on final timeout cycle ----------------
        tick();                                     // WAIT cycle 1
        for (int j = 0; j < 14; j++) tick();        // WAIT cycle 15
        mem_valid = 1'b1;
        mem_inst  = 32'hCAFEF00D;
        tick();
        mem_valid = 1'b0;
        chk("co_m0_valid", 32'(m0_valid), 32'h1);
        chk("co_m0_err",   32'(m0_err),   32'h0);
        chk("co_m0_data",  m0_data,       32'hCAFEF00D);

        // ---------------- stray mem_valid in IDLE ----------------
        mem_valid = 1'b1;
        mem_inst  = 32'h12345678;
        tick();
        mem_valid = 1'b0;
        chk("st_valids", 32'({m0_valid, m1_valid}), 32'h0);
        chk("st_busy",   32'(busy),    32'h0);
        chk("st_m0_data", m0_data,     32'hCAFEF00D);

        // ---------------- reset during WAIT ----------------
        m1_req  = 1'b1;
        m1_addr = 7'h44;
        tick();                                     // ISSUE
        chk("rw_m1_gnt", 32'(m1_gnt), 32'h1);
        m1_req = 1'b0;
        tick();                                     // WAIT
        rst_n = 1'b0;
        #1;
        chk("rw_busy",    32'(busy),     32'h0);
        chk("rw_memaddr", 32'(mem_addr), 32'h0);
        chk("rw_m0_data", m0_data,       32'h0);
        tick();
        rst_n     = 1'b1;
        mem_valid = 1'b1;
        mem_inst  = 32'h55AA55AA;
        tick();
        mem_valid = 1'b0;
        chk("rw_late_valid", 32'(m1_valid), 32'h0);
        chk("rw_m1_data",    m1_data,       32'h0);
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m0_addr = 7'h01;
        m1_addr = 7'h02;
        tick();
        chk("rw_tie_m0", 32'(m0_gnt), 32'h1);
        chk("rw_tie_m1", 32'(m1_gnt), 32'h0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();                                     // WAIT
        mem_valid = 1'b1;
        mem_inst  = 32'h11112222;
        tick();
        mem_valid = 1'b0;
        chk("rw_m0_valid", 32'(m0_valid), 32'h1);
        chk("rw_m0_dat2",  m0_data,       32'h11112222);

        // ---------------- request withdrawn before IDLE ----------------
        m0_req  = 1'b1;
        m0_addr = 7'h07;
        tick();                                     // ISSUE
        chk("wd_m0_gnt", 32'(m0_gnt), 32'h1);
        m0_req = 1'b0;
        tick();                                     // WAIT
        m1_req = 1'b1;
        tick();
        m1_req = 1'b0;
        chk("wd_m1_gnt_a", 32'(m1_gnt), 32'h0);
        tick();
        mem_valid = 1'b1;
        mem_inst  = 32'h0BADF00D;
        tick();                                     // IDLE
        mem_valid = 1'b0;
        chk("wd_m0_valid", 32'(m0_valid), 32'h1);
        tick();
        chk("wd_m1_gnt_b", 32'(m1_gnt), 32'h0);
        chk("wd_busy",     32'(busy),   32'h0);
        tick();
        chk("wd_m1_gnt_c", 32'(m1_gnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port (request/addr/valid/fetched_inst) between two requesters: port 0 (fetch FSM) and port 1 (loader/debug reader).
- Round-robin arbitration; one outstanding memory transaction at a time; per-transaction timeout.
- Sits between the requesters and inst_mem.
- All outputs are registered.

Parameters:
INST_WIDTH, 32, instruction data width
INST_ADDR_WIDTH, 7, instruction address width
TIMEOUT, 15, max WAIT cycles before a transaction is aborted (>=1)
TMR_WIDTH, 4, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  port 0 request; hold with m0_addr stable until m0_gnt
m0_addr  input  INST_ADDR_WIDTH  port 0 address
m0_gnt  output  1  one-cycle pulse: port 0 request accepted
m0_valid  output  1  one-cycle pulse: m0_data valid
m0_err  output  1  one-cycle pulse: port 0 transaction timed out
m0_data  output  INST_WIDTH  returned instruction
m1_req, m1_addr, m1_gnt, m1_valid, m1_err, m1_data  same as port 0, for port 1
mem_request  output  1  one-cycle request pulse to inst_mem
mem_addr  output  INST_ADDR_WIDTH  address to inst_mem, held from ISSUE until return to IDLE
mem_valid  input  1  inst_mem response strobe
mem_inst  input  INST_WIDTH  inst_mem response data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: clk and rst_n only; rst_n is asynchronous and active-low.
- While rst_n is low:
  - state = IDLE; all gnt/valid/err/mem_request/busy = 0.
  - m*_data = 0; mem_addr = 0; timer = 0.
  - last_owner = 1, so port 0 wins the first tie.
- Reset asserted mid-transaction aborts it silently: no valid/err pulse; any later mem_valid is ignored until the next ISSUE.
- IDLE:
  - Sample m0_req/m1_req.
  - If only one is high, select it. If both are high, select the port != last_owner.
  - Latch the owner and its address; go to ISSUE. If neither is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mx_gnt = 1 for the owner, mem_request = 1, mem_addr = latched address.
  - Clear the timer; go to WAIT.
- WAIT:
  - mem_request = 0; mem_addr held.
  - If mem_valid: next cycle mx_valid = 1 and mx_data = mem_inst (captured); last_owner = owner; go to IDLE.
  - Else if timer == TIMEOUT-1: next cycle mx_err = 1 and mx_data = 0; last_owner = owner; go to IDLE.
  - Else timer += 1.
  - If mem_valid and timeout coincide, mem_valid wins: valid pulse, no err.
- Latency (req high at IDLE cycle t):
  - gnt and mem_request at t+1; WAIT from t+2.
  - mem_valid at cycle k>=t+2 gives mx_valid at k+1.
  - Next grant is at the earliest k+2 (the IDLE cycle is k+1).
- mem_valid sampled in IDLE or ISSUE is ignored (stray responses are dropped).
- Requester rules:
  - req may drop before gnt without effect; arbitration only samples req in IDLE.
  - req still high when the arbiter returns to IDLE counts as a new request.
- Non-owner port outputs stay 0 throughout a transaction. mx_data holds its last value except when overwritten by a valid or err return.
- busy = 1 in ISSUE and WAIT.

Test Plan:
- Single request, m0_req=1 with m0_addr=7'h05 at IDLE; inst_mem returns 32'hDEADBEEF 2 cycles after mem_request -> m0_gnt and mem_request at t+1 with mem_addr=5; m0_valid at t+4 with m0_data=32'hDEADBEEF; m1 outputs stay 0.
- Both requesting continuously, addresses 0x10 and 0x20, 1-cycle memory -> grants alternate m0, m1, m0, m1 (m0 first after reset); each mem_addr matches its owner; no data cross-routing.
- Timeout, TIMEOUT=15, m1 requests and mem_valid never asserts -> m1_err pulses 16 cycles after m1_gnt with m1_data=0; busy drops on that cycle; the next m0 request is granted.
- Coincident mem_valid on the final timeout cycle -> m0_valid=1, m0_err=0, data captured.
- Stray mem_valid in IDLE -> no valid pulse. Reset pulse during WAIT -> all outputs 0 immediately; later mem_valid ignored; post-reset tie grants port 0.
- req withdrawn before IDLE: m1_req pulses high for 1 cycle during a port-0 WAIT -> no m1_gnt ever issued.
